// File: rtl/axi_lite_regfile_slave.sv
// AXI4-Lite slave backed by a DEPTH-word register file.
// AW and W are captured into one-beat holds independently; a write commits once both are held.
module axi_lite_regfile_slave #(
  parameter int                DATA_W    = 32,
  parameter int                ADDR_W    = 8,
  parameter int                DEPTH     = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                awvalid,
  output logic                awready,
  input  logic [ADDR_W-1:0]   awaddr,
  input  logic                wvalid,
  output logic                wready,
  input  logic [DATA_W-1:0]   w_data,
  input  logic [DATA_W/8-1:0] wstrb,
  output logic                bvalid,
  input  logic                bready,
  output logic [1:0]          bresp,
  input  logic                arvalid,
  output logic                arready,
  input  logic [ADDR_W-1:0]   araddr,
  output logic                rvalid,
  input  logic                rready,
  output logic [DATA_W-1:0]   r_data,
  output logic [1:0]          rresp
);

  localparam int              NB      = DATA_W / 8;
  localparam int              BYTE_SH = $clog2(NB);
  localparam int              IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);
  localparam logic [1:0]      OKAY    = 2'b00;
  localparam logic [1:0]      SLVERR  = 2'b10;

  logic              live;
  logic              aw_full;
  logic              w_full;
  logic [ADDR_W-1:0] aw_addr_q;
  logic [DATA_W-1:0] w_data_q;
  logic [NB-1:0]     w_strb_q;
  logic [DATA_W-1:0] mem [DEPTH];

  logic [ADDR_W-1:0] aw_idx;
  logic [ADDR_W-1:0] ar_idx;
  logic              aw_in_range;
  logic              ar_in_range;
  logic              commit;

  assign aw_idx      = aw_addr_q >> BYTE_SH;
  assign ar_idx      = araddr >> BYTE_SH;
  assign aw_in_range = {1'b0, aw_idx} < DEPTH_L;
  assign ar_in_range = {1'b0, ar_idx} < DEPTH_L;

  // Readies stay low through reset and come up the cycle after release.
  assign awready = live & ~aw_full;
  assign wready  = live & ~w_full;
  assign arready = live & ~rvalid;

  // A pending B response blocks the next commit unless it retires this cycle.
  assign commit = aw_full & w_full & (~bvalid | bready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      live      <= 1'b0;
      aw_full   <= 1'b0;
      w_full    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid    <= 1'b0;
      bresp     <= OKAY;
      rvalid    <= 1'b0;
      r_data    <= '0;
      rresp     <= OKAY;
      for (int i = 0; i < DEPTH; i++) mem[i] <= RESET_VAL;
    end else begin
      live <= 1'b1;

      if (awvalid && awready) begin
        aw_full   <= 1'b1;
        aw_addr_q <= awaddr;
      end
      if (wvalid && wready) begin
        w_full   <= 1'b1;
        w_data_q <= w_data;
        w_strb_q <= wstrb;
      end

      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= aw_in_range ? OKAY : SLVERR;
        if (aw_in_range) begin
          for (int b = 0; b < NB; b++)
            if (w_strb_q[b]) mem[aw_idx[IDX_W-1:0]][b*8 +: 8] <= w_data_q[b*8 +: 8];
        end
      end else if (bvalid && bready) begin
        bvalid <= 1'b0;
      end

      // Non-blocking update means a same-cycle commit is not seen by this read.
      if (arvalid && arready) begin
        rvalid <= 1'b1;
        r_data <= ar_in_range ? mem[ar_idx[IDX_W-1:0]] : '0;
        rresp  <= ar_in_range ? OKAY : SLVERR;
      end else if (rvalid && rready) begin
        rvalid <= 1'b0;
      end
    end
  end

endmodule
